vid_fetch: RTL and testbench

Framebuffer fetch engine on the memory side of the display controller's read port. It issues burst reads to the SDRAM controller and buffers the returned words in a prefetch FIFO. Each display `req` is answered with the next sequential 32-bit word on `viddata`, two 16-bit pixels per word. The read pointer restarts at the frame base on every frame-start pulse.

---
 rtl/vid_fetch_if.sv | 27 ++
 rtl/vid_fetch.sv | 215 +++++++++++++++++++++
 tb/tb_vid_fetch.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vid_fetch_if.sv
// Memory-side read bus between vid_fetch and the SDRAM controller.
// master: mem_rd/mem_adr out, mem_ack/mem_valid/mem_rdata in.
interface vid_fetch_if #(
  parameter int ADR_W = 24
);
  logic             mem_rd;
  logic [ADR_W-1:0] mem_adr;
  logic             mem_ack;
  logic             mem_valid;
  logic [31:0]      mem_rdata;

  modport master (
    output mem_rd,
    output mem_adr,
    input  mem_ack,
    input  mem_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd,
    input  mem_adr,
    output mem_ack,
    output mem_valid,
    output mem_rdata
  );
endinterface

// File: rtl/vid_fetch.sv
// Framebuffer fetch engine: issues SDRAM bursts into a prefetch FIFO
// and hands one 32-bit word (two 16-bit pixels) to the display per req.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   frame_start_i  restart frame at fb_base_i, flush FIFO, clear underrun
//   fb_base_i      frame base word address
//   req_i          consume one word this cycle
//   viddata_o      registered FIFO head
//   underrun_o     sticky: req seen with empty FIFO
//   mem            vid_fetch_if.master burst read bus
// Optional (`define VID_FETCH_STATS_EN):
//   underrun_cnt_o saturating count of empty-FIFO req cycles
//   fifo_low_o     lowest FIFO fill since last frame_start
module vid_fetch #(
  parameter int ADR_W       = 24,
  parameter int FRAME_WORDS = 153600,
  parameter int BURST       = 8,
  parameter int FIFO_DEPTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start_i,
  input  logic [ADR_W-1:0] fb_base_i,
  input  logic             req_i,
  output logic [31:0]      viddata_o,
  output logic             underrun_o,
`ifdef VID_FETCH_STATS_EN
  output logic [15:0]      underrun_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_low_o,
`endif
  vid_fetch_if.master      mem
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int FS_W = CW + 1;
  localparam int RW   = $clog2(FRAME_WORDS + 1);
  localparam int BW   = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DRAIN
  } state_t;

  state_t           state_q;
  logic [ADR_W-1:0] fptr_q;
  logic [RW-1:0]    remain_q;
  logic [BW-1:0]    inflight_q;
  logic             mem_rd_q;
  logic [ADR_W-1:0] mem_adr_q;

  logic [31:0]      fifo_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [31:0]      viddata_q;
  logic             underrun_q;

  logic             push;
  logic             pop;
  logic             empty_req;
  logic [FS_W-1:0]  free;
  logic             fetch_go;

  assign mem.mem_rd  = mem_rd_q;
  assign mem.mem_adr = mem_adr_q;
  assign viddata_o   = viddata_q;
  assign underrun_o  = underrun_q;

  // Words returned after a frame_start (DRAIN) never reach the FIFO.
  assign push = (state_q == DATA)
              && mem.mem_valid
              && !frame_start_i;

  assign pop = req_i
             && (count_q != '0)
             && !frame_start_i;

  assign empty_req = req_i
                   && (count_q == '0)
                   && !frame_start_i;

  // Inflight words already own FIFO slots, so an accepted
  // burst always fits.
  assign free = FS_W'(FIFO_DEPTH)
              - FS_W'(count_q)
              - FS_W'(inflight_q);

  assign fetch_go = (remain_q != '0)
                  && (free >= FS_W'(BURST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fptr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_adr_q  <= '0;
    end else begin
      if (frame_start_i) begin
        fptr_q   <= fb_base_i;
        remain_q <= RW'(FRAME_WORDS);
      end
      unique case (state_q)
        IDLE: begin
          if (!frame_start_i && fetch_go) begin
            state_q   <= REQ;
            mem_rd_q  <= 1'b1;
            mem_adr_q <= fptr_q;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            // Accepted even if a frame_start coincides;
            // its data must then be drained.
            mem_rd_q   <= 1'b0;
            inflight_q <= BW'(BURST);
            if (frame_start_i) begin
              state_q <= DRAIN;
            end else begin
              state_q <= DATA;
              fptr_q  <= fptr_q + ADR_W'(BURST);
              if (remain_q > RW'(BURST))
                remain_q <= remain_q - RW'(BURST);
              else
                remain_q <= '0;
            end
          end else if (frame_start_i) begin
            mem_rd_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        DATA, DRAIN: begin
          if (mem.mem_valid && inflight_q != '0)
            inflight_q <= inflight_q - BW'(1);
          if (mem.mem_valid && inflight_q == BW'(1))
            state_q <= IDLE;
          else if (frame_start_i)
            state_q <= DRAIN;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (frame_start_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr_q] <= mem.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      viddata_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Head only moves when a word will be present; an
      // empty FIFO keeps showing the last word.
      if (count_d != '0) begin
        if (push && count_q == CW'(pop))
          viddata_q <= mem.mem_rdata;
        else
          viddata_q <= fifo_q[rd_ptr_d];
      end
      if (frame_start_i)
        underrun_q <= 1'b0;
      else if (empty_req)
        underrun_q <= 1'b1;
    end
  end

`ifdef VID_FETCH_STATS_EN
  logic [15:0]   unr_cnt_q;
  logic [CW-1:0] low_q;

  assign underrun_cnt_o = unr_cnt_q;
  assign fifo_low_o     = low_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      unr_cnt_q <= '0;
      low_q     <= CW'(FIFO_DEPTH);
    end else begin
      if (empty_req && unr_cnt_q != 16'hFFFF)
        unr_cnt_q <= unr_cnt_q + 16'd1;
      if (frame_start_i)
        low_q <= CW'(FIFO_DEPTH);
      else if (count_q < low_q)
        low_q <= count_q;
    end
  end
`endif

endmodule

// File: tb/tb_vid_fetch.sv
// Scoreboard bench for vid_fetch: a burst memory model returns
// data = address; expected words queue up as they are returned.
module tb_vid_fetch;

  localparam int FW    = 2560;
  localparam int BURST = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start_i;
  logic [23:0] fb_base_i;
  logic        req_i;
  logic [31:0] viddata_o;
  logic        underrun_o;
`ifdef VID_FETCH_STATS_EN
  logic [15:0] underrun_cnt_o;
  logic [5:0]  fifo_low_o;
`endif

  vid_fetch_if #(.ADR_W(24)) bus ();

  vid_fetch #(
    .ADR_W       (24),
    .FRAME_WORDS (FW),
    .BURST       (BURST),
    .FIFO_DEPTH  (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start_i (frame_start_i),
    .fb_base_i     (fb_base_i),
    .req_i         (req_i),
    .viddata_o     (viddata_o),
    .underrun_o    (underrun_o),
`ifdef VID_FETCH_STATS_EN
    .underrun_cnt_o(underrun_cnt_o),
    .fifo_low_o    (fifo_low_o),
`endif
    .mem           (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb [$];
  logic [23:0] adr_log [$];
  logic [31:0] exp_vid = '0;
  logic        exp_unr = 1'b0;
  int          n_unr_ev = 0;
  int          n_pop = 0;
  int          n_burst = 0;
  logic [23:0] last_adr = '0;
  logic        hold_ack = 1'b0;
  int          m_wait = 0;
  int          m_words = 0;
  logic        m_acked = 1'b0;
  logic        m_disc = 1'b0;
  logic [23:0] m_addr = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, compare popped head,
  // then run the memory model.
  task automatic cyc(input logic fs,
                     input logic [23:0] base,
                     input logic rq);
    logic [31:0] w;
    @(negedge clk);
    frame_start_i = fs;
    fb_base_i     = base;
    req_i         = rq;
    if (rq && !fs) begin
      if (sb.size() != 0) begin
        w = sb.pop_front();
        chk("viddata", viddata_o, w);
        exp_vid = w;
        n_pop++;
      end else begin
        exp_unr = 1'b1;
        n_unr_ev++;
      end
    end
    bus.mem_ack   = 1'b0;
    bus.mem_valid = 1'b0;
    if (m_acked) begin
      m_acked = 1'b0;
      m_words = BURST;
    end
    if (fs) begin
      sb.delete();
      exp_unr = 1'b0;
      if (m_words != 0) m_disc = 1'b1;
    end
    if (m_words != 0 && !fs) begin
      bus.mem_valid = 1'b1;
      bus.mem_rdata = {8'h00, m_addr};
      if (!m_disc) sb.push_back({8'h00, m_addr});
      m_addr  = m_addr + 24'd1;
      m_words = m_words - 1;
    end else if (m_words == 0) begin
      if (bus.mem_rd && !hold_ack && !fs) begin
        m_wait++;
        if (m_wait >= 2) begin
          bus.mem_ack = 1'b1;
          m_wait   = 0;
          m_acked  = 1'b1;
          m_disc   = 1'b0;
          m_addr   = bus.mem_adr;
          last_adr = bus.mem_adr;
          adr_log.push_back(bus.mem_adr);
          n_burst++;
        end
      end else begin
        m_wait = 0;
      end
    end
    if (sb.size() != 0) exp_vid = sb[0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 24'h0, 1'b0);
  endtask

  initial begin
    int b0;
    int p0;
    rst = 1'b1;
    frame_start_i = 1'b0;
    fb_base_i = '0;
    req_i = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_adr", bus.mem_adr, 0);
    chk("rst_underrun", underrun_o, 0);
    chk("rst_viddata", viddata_o, 0);
`ifdef VID_FETCH_STATS_EN
    chk("rst_unr_cnt", underrun_cnt_o, 0);
    chk("rst_fifo_low", fifo_low_o, 32);
`endif
    rst = 1'b0;
    idle(6);
    chk("no_fetch_pre_fs", bus.mem_rd, 0);

    // Prefetch without consumption fills exactly 4 bursts.
    cyc(1'b1, 24'h010000, 1'b0);
    idle(200);
    chk("adr0", adr_log[0], 32'h010000);
    chk("adr1", adr_log[1], 32'h010008);
    chk("bursts_full", n_burst, 4);
    chk("stop_full", bus.mem_rd, 0);

    // Whole frame, req every other cycle.
    for (int c = 0; c < 30000 && n_pop < FW; c++)
      cyc(1'b0, 24'h0, c[0]);
    chk("frame_pops", n_pop, FW);
    idle(60);
    chk("frame_bursts", n_burst, FW / BURST);
    chk("frame_unr", underrun_o, exp_unr);
    chk("frame_unr0", underrun_o, 0);
    chk("frame_done_rd", bus.mem_rd, 0);

    // Starved FIFO: ack withheld, three reqs.
    hold_ack = 1'b1;
    cyc(1'b1, 24'h030000, 1'b0);
    idle(4);
    chk("stuck_rd", bus.mem_rd, 1);
    chk("stuck_adr", bus.mem_adr, 32'h030000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 24'h0, 1'b1);
      cyc(1'b0, 24'h0, 1'b0);
    end
    chk("unr_set", underrun_o, exp_unr);
    chk("unr_hold_vid", viddata_o, exp_vid);
`ifdef VID_FETCH_STATS_EN
    chk("unr_cnt3", underrun_cnt_o, n_unr_ev);
`endif
    cyc(1'b1, 24'h040000, 1'b0);
    idle(1);
    chk("unr_clr", underrun_o, exp_unr);
    chk("req_drop", bus.mem_rd, 0);
    hold_ack = 1'b0;

    // Frame restart in the middle of a burst.
    for (int i = 0; i < 60 && m_words != 5; i++) idle(1);
    chk("mid_burst", m_words, 5);
    b0 = n_burst;
    cyc(1'b1, 24'h200000, 1'b0);
    for (int i = 0; i < 60 && n_burst == b0; i++) idle(1);
    chk("drain_adr", last_adr, 32'h200000);
    for (int i = 0; i < 40; i++) cyc(1'b0, 24'h0, i[0]);
    chk("drain_unr", underrun_o, exp_unr);
    idle(100);

    // Push and pop together while one word deep.
    cyc(1'b1, 24'h300000, 1'b0);
    for (int i = 0; i < 60 && sb.size() == 0; i++) idle(1);
    p0 = n_pop;
    for (int i = 0; i < BURST; i++) cyc(1'b0, 24'h0, 1'b1);
    idle(1);
    chk("coll_pops", n_pop - p0, BURST);
    chk("coll_unr", underrun_o, 0);

`ifdef VID_FETCH_STATS_EN
    hold_ack = 1'b1;
    cyc(1'b1, 24'h500000, 1'b0);
    for (int i = 0; i < 70000; i++) cyc(1'b0, 24'h0, 1'b1);
    idle(1);
    chk("unr_sat", underrun_cnt_o,
        (n_unr_ev > 65535) ? 32'hFFFF : n_unr_ev);
    chk("fifo_low", fifo_low_o, 0);
    chk("sat_unr", underrun_o, exp_unr);
    hold_ack = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
